// File: rtl/ex_muldiv_pkg.sv
// Shared op-codes, FSM encodings and op-decode helpers for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

  localparam int unsigned MD_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    EXE_MD_MULT  = 3'b000,
    EXE_MD_MULTU = 3'b001,
    EXE_MD_MADD  = 3'b010,
    EXE_MD_MADDU = 3'b011,
    EXE_MD_MSUB  = 3'b100,
    EXE_MD_MSUBU = 3'b101,
    EXE_MD_DIV   = 3'b110,
    EXE_MD_DIVU  = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE       = 3'd0,
    MD_MUL        = 3'd1,
    MD_ACC        = 3'd2,
    MD_DIV_ON     = 3'd3,
    MD_DIV_BYZERO = 3'd4,
    MD_DONE       = 3'd5
  } md_state_e;

  // Even op-codes are the signed variants.
  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic md_is_mul_only(input md_op_e op);
    return ~op[2] & ~op[1];
  endfunction

  function automatic logic md_is_sub(input md_op_e op);
    return op[2] & ~op[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage <-> multiply/divide unit request/response bundle.
interface ex_muldiv_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic                       start_i;
  ex_muldiv_pkg::md_op_e      op_i;
  logic [WIDTH-1:0]           opdata1_i;
  logic [WIDTH-1:0]           opdata2_i;
  logic [2*WIDTH-1:0]         hilo_i;
  logic                       annul_i;
  logic [2*WIDTH-1:0]         result_o;
  logic                       ready_o;
  logic                       stallreq_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/ex_muldiv_div_iter.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module ex_muldiv_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   part_i,     // {partial remainder, next dividend bit}
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_c,
  output logic             qbit_c
);

  logic [WIDTH:0] diff;

  // part_i < 2*divisor, so the MSB of the difference is a clean borrow flag.
  always_comb begin
    diff   = part_i - {1'b0, divisor_i};
    qbit_c = ~diff[WIDTH];
    rem_c  = qbit_c ? diff[WIDTH-1:0] : part_i[WIDTH-1:0];
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MADD/MSUB/DIV unit beside the EX ALU; produces {HI,LO} with a ready pulse.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH_DEF
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < 8 || (WIDTH % 2) != 0) begin : g_width_chk
    $error("ex_muldiv: WIDTH must be even and at least 8");
  end

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic             sign1_q, sign1_d, sign2_q, sign2_d;
  logic [WIDTH-1:0] mag1_q, mag1_d, mag2_q, mag2_d;
  logic [DW-1:0]    prod_q, prod_d;
  logic [DW-1:0]    work_q, work_d;
  logic [DW-1:0]    result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;

  logic             in_signed, in_sign1, in_sign2;
  logic [DW-1:0]    prod_mag;
  logic [WIDTH-1:0] rem_c;
  logic             qbit_c;
  logic [WIDTH-1:0] quot_fix, rem_fix, op1_raw;

  // work_q holds {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  ex_muldiv_div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .part_i    ({work_q[DW-1:WIDTH], work_q[WIDTH-1]}),
    .divisor_i (mag2_q),
    .rem_c     (rem_c),
    .qbit_c    (qbit_c)
  );

  // Next-state and next-register logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    mag1_d   = mag1_q;
    mag2_d   = mag2_q;
    prod_d   = prod_q;
    work_d   = work_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    quot_fix = '0;
    rem_fix  = '0;
    op1_raw  = sign1_q ? -mag1_q : mag1_q;

    in_signed = md_is_signed(bus.op_i);
    in_sign1  = in_signed & bus.opdata1_i[WIDTH-1];
    in_sign2  = in_signed & bus.opdata2_i[WIDTH-1];
    prod_mag  = DW'(mag1_q) * DW'(mag2_q);

    unique case (state_q)
      MD_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          op_d    = bus.op_i;
          sign1_d = in_sign1;
          sign2_d = in_sign2;
          mag1_d  = in_sign1 ? -bus.opdata1_i : bus.opdata1_i;
          mag2_d  = in_sign2 ? -bus.opdata2_i : bus.opdata2_i;
          cnt_d   = '0;
          if (!md_is_div(bus.op_i)) begin
            state_d = MD_MUL;
          end else if (bus.opdata2_i == '0) begin
            state_d = MD_DIV_BYZERO;
          end else begin
            work_d  = {WIDTH'(0), mag1_d};
            state_d = MD_DIV_ON;
          end
        end
      end

      MD_MUL: begin
        prod_d = (sign1_q ^ sign2_q) ? -prod_mag : prod_mag;
        if (md_is_mul_only(op_q)) begin
          result_d = prod_d;
          ready_d  = 1'b1;
          state_d  = MD_DONE;
        end else begin
          state_d  = MD_ACC;
        end
      end

      MD_ACC: begin
        result_d = md_is_sub(op_q) ? (bus.hilo_i - prod_q) : (bus.hilo_i + prod_q);
        ready_d  = 1'b1;
        state_d  = MD_DONE;
      end

      MD_DIV_ON: begin
        work_d = {rem_c, work_q[WIDTH-2:0], qbit_c};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          quot_fix = (sign1_q ^ sign2_q) ? -work_d[WIDTH-1:0] : work_d[WIDTH-1:0];
          rem_fix  = sign1_q ? -work_d[DW-1:WIDTH] : work_d[DW-1:WIDTH];
          result_d = {rem_fix, quot_fix};
          cnt_d    = '0;
          ready_d  = 1'b1;
          state_d  = MD_DONE;
        end
      end

      MD_DIV_BYZERO: begin
        result_d = {op1_raw, {WIDTH{1'b1}}};
        ready_d  = 1'b1;
        state_d  = MD_DONE;
      end

      MD_DONE: state_d = MD_IDLE;

      default: state_d = MD_IDLE;
    endcase

    // Cancel wins over everything: no ready pulse, result_o keeps its last value.
    if (bus.annul_i) begin
      state_d  = MD_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MD_IDLE;
      op_q     <= EXE_MD_MULT;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      mag1_q   <= '0;
      mag2_q   <= '0;
      prod_q   <= '0;
      work_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      mag1_q   <= mag1_d;
      mag2_q   <= mag2_d;
      prod_q   <= prod_d;
      work_q   <= work_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  // Stall is combinational so EX holds in the same cycle the request is accepted.
  assign bus.stallreq_o = rst &&
                          ((state_q == MD_IDLE && bus.start_i && !bus.annul_i) ||
                           (state_q != MD_IDLE && state_q != MD_DONE));

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed scoreboard bench for ex_muldiv at WIDTH=32.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_total;
  logic saw_ready;

  typedef struct {
    string       name;
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  ex_muldiv_if #(.WIDTH(W)) bus ();

  ex_muldiv #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every ready pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    if (rst && bus.ready_o) begin
      saw_ready = 1'b1;
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ready: result %h with nothing expected (cycle %0d)",
                 bus.result_o, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_result"}, bus.result_o, e.res);
        chk({e.name, "_ready_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one op, push its expectation, check stallreq each cycle through DONE.
  task automatic run_op(input string name, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hilo,
                        input logic [63:0] exp, input int lat);
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.hilo_i    = hilo;
    sb_q.push_back('{name, exp, cyc + lat});
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      chk({name, "_stall"}, 64'(bus.stallreq_o), 64'(i < lat));
      @(posedge clk); #1;
      bus.start_i   = 1'b0;
      // Operand churn while busy must not affect the result.
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
    end
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    saw_ready     = 1'b0;
    rst           = 1'b0;
    bus.start_i   = 1'b1;
    bus.op_i      = EXE_MD_MULT;
    bus.opdata1_i = 32'd1;
    bus.opdata2_i = 32'd1;
    bus.hilo_i    = '0;
    bus.annul_i   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result", bus.result_o, 64'h0);
    chk("reset_ready", 64'(bus.ready_o), 64'h0);
    chk("reset_stall", 64'(bus.stallreq_o), 64'h0);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    rst         = 1'b1;

    run_op("mult_neg", EXE_MD_MULT, 32'hFFFFFFFD, 32'd5, 64'h0, 64'hFFFFFFFF_FFFFFFF1, 2);
    run_op("maddu", EXE_MD_MADDU, 32'hFFFFFFFF, 32'd2, 64'h1, 64'h00000001_FFFFFFFF, 3);
    run_op("msub", EXE_MD_MSUB, 32'd2, 32'd3, 64'd10, 64'h0000000000000004, 3);
    run_op("msubu_wrap", EXE_MD_MSUBU, 32'd1, 32'd1, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 3);
    run_op("div_neg", EXE_MD_DIV, 32'hFFFFFFF9, 32'd2, 64'h0, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_op("div_negdiv", EXE_MD_DIV, 32'd7, 32'hFFFFFFFE, 64'h0, {32'h00000001, 32'hFFFFFFFD}, 33);
    run_op("divu_zero", EXE_MD_DIVU, 32'd5, 32'd0, 64'h0, {32'h00000005, 32'hFFFFFFFF}, 2);

    // annul has priority over start in IDLE.
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    bus.op_i      = EXE_MD_MULT;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd9;
    #1 chk("annul_prio_stall0", 64'(bus.stallreq_o), 64'h0);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    @(negedge clk);
    chk("annul_prio_stall1", 64'(bus.stallreq_o), 64'h0);

    // DIVU 100/7 cancelled at cycle 10.
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.op_i      = EXE_MD_DIVU;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.annul_i = 1'b1;
    @(negedge clk);
    chk("annul_stall_c10", 64'(bus.stallreq_o), 64'h1);
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    saw_ready   = 1'b0;
    @(negedge clk);
    chk("annul_stall_c11", 64'(bus.stallreq_o), 64'h0);
    chk("annul_result_kept", bus.result_o, {32'h00000005, 32'hFFFFFFFF});
    repeat (40) @(negedge clk);
    chk("annul_no_ready", 64'(saw_ready), 64'h0);
    chk("annul_result_still", bus.result_o, {32'h00000005, 32'hFFFFFFFF});

    // Asynchronous reset at cycle 5 of a DIV.
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.op_i      = EXE_MD_DIV;
    bus.opdata1_i = 32'hFFFFFFF9;
    bus.opdata2_i = 32'd2;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_pre_stall", 64'(bus.stallreq_o), 64'h1);
    rst = 1'b0;
    #1;
    chk("rst_async_result", bus.result_o, 64'h0);
    chk("rst_async_ready", 64'(bus.ready_o), 64'h0);
    chk("rst_async_stall", 64'(bus.stallreq_o), 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;

    run_op("multu_after_rst", EXE_MD_MULTU, 32'd3, 32'd4, 64'h0, 64'h000000000000000C, 2);
    repeat (40) @(negedge clk);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
